// File: rtl/counter_pkg.sv
// Shared mode constants and load clamping for counter_mod.
package counter_pkg;

    typedef logic [1:0] counter_mode_t;

    localparam counter_mode_t MODE_WRAP    = 2'd0;
    localparam counter_mode_t MODE_SAT     = 2'd1;
    localparam counter_mode_t MODE_ONESHOT = 2'd2;

    // Out-of-range load values land on the top of the count range.
    function automatic int unsigned clamp_load(input int unsigned val, input int unsigned modulo);
        return (val >= modulo) ? modulo - 1 : val;
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Enable prescaler for counter_mod: strobes once every PRE_DIV enabled cycles.
// Only instantiated when COUNTER_MOD_PRESCALE_EN is defined.
module counter_prescaler #(
    parameter int PRE_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic clr_i,
    output logic strobe_o
);

    localparam int PW = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRE_DIV - 1);

    logic [PW-1:0] pre_reg;
    logic [PW-1:0] pre_next;

    assign strobe_o = en_i & (pre_reg == LAST);

    always_comb begin
        pre_next = pre_reg;
        if (clr_i) begin
            pre_next = '0;
        end else if (en_i) begin
            pre_next = (pre_reg == LAST) ? '0 : pre_reg + PW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pre_reg <= '0;
        end else begin
            pre_reg <= pre_next;
        end
    end

endmodule

// File: rtl/counter_mod.sv
// Parametrised up/down counter with wrap, saturate and one-shot terminal modes.
// Optional enable prescaler under `define COUNTER_MOD_PRESCALE_EN (parameter PRE_DIV).
module counter_mod
    import counter_pkg::*;
#(
    parameter int            BW      = 8,
    parameter int            MODULO  = 2**BW,
    parameter counter_mode_t MODE    = MODE_WRAP,
    parameter int            RST_VAL = 0
`ifdef COUNTER_MOD_PRESCALE_EN
    ,
    parameter int            PRE_DIV = 4
`endif
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          en_i,
    input  logic          up_i,
    input  logic          clr_i,
    input  logic          load_i,
    input  logic [BW-1:0] load_val_i,
    output logic [BW-1:0] counter_val_o,
    output logic          tc_o,
    output logic          wrap_o,
    output logic          done_o
);

    localparam logic [BW-1:0] MAX_CNT = BW'(MODULO - 1);
    localparam logic [BW-1:0] RST_CNT = BW'(RST_VAL);

    logic [BW-1:0] count_reg;
    logic [BW-1:0] count_next;
    logic          wrap_reg;
    logic          wrap_next;
    logic          done_reg;
    logic          done_next;
    logic          strobe;
    logic          at_term;
    logic [BW-1:0] load_clamped;

`ifdef COUNTER_MOD_PRESCALE_EN
    counter_prescaler #(
        .PRE_DIV (PRE_DIV)
    ) u_prescaler (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .en_i     (en_i),
        .clr_i    (clr_i | load_i),
        .strobe_o (strobe)
    );
`else
    assign strobe = en_i;
`endif

    assign load_clamped = BW'(clamp_load(32'(load_val_i), 32'(MODULO)));
    assign at_term      = up_i ? (count_reg == MAX_CNT) : (count_reg == '0);

    assign tc_o          = strobe & at_term & ~done_reg;
    assign counter_val_o = count_reg;
    assign wrap_o        = wrap_reg;
    assign done_o        = done_reg;

    // Terminal handling is explicit so non-power-of-two moduli wrap correctly.
    always_comb begin
        count_next = count_reg;
        wrap_next  = 1'b0;
        done_next  = done_reg;
        if (clr_i) begin
            count_next = RST_CNT;
            done_next  = 1'b0;
        end else if (load_i) begin
            count_next = load_clamped;
            done_next  = 1'b0;
        end else if (strobe && !done_reg) begin
            if (!at_term) begin
                count_next = up_i ? count_reg + BW'(1) : count_reg - BW'(1);
            end else begin
                case (MODE)
                    MODE_WRAP: begin
                        count_next = up_i ? '0 : MAX_CNT;
                        wrap_next  = 1'b1;
                    end
                    MODE_ONESHOT: begin
                        done_next = 1'b1;
                    end
                    default: begin
                        count_next = count_reg;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_reg <= RST_CNT;
            wrap_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            count_reg <= count_next;
            wrap_reg  <= wrap_next;
            done_reg  <= done_next;
        end
    end

endmodule

// File: tb/tb_counter_mod.sv
// Bench for counter_mod: five configurations driven in parallel and compared
// every cycle against an arithmetic reference model.
module tb_counter_mod;
    import counter_pkg::*;

`ifdef COUNTER_MOD_PRESCALE_EN
    localparam int PRE_DIV = 4;
`else
    localparam int PRE_DIV = 1;
`endif
    localparam int NDUT = 5;

    // configuration table: a=3b/8 wrap, b=4b/10 wrap rst3, c=8b/256 sat, d=4b/16 oneshot, e=1b/2 wrap
    int unsigned cfg_bw   [NDUT] = '{3, 4, 8, 4, 1};
    int unsigned cfg_mod  [NDUT] = '{8, 10, 256, 16, 2};
    int unsigned cfg_mode [NDUT] = '{0, 0, 1, 2, 0};
    int unsigned cfg_rst  [NDUT] = '{0, 3, 0, 0, 0};

    logic clk = 1'b0;
    logic rst_n, en, up, clr, load;
    logic [15:0] lv;

    logic [2:0] q_a;
    logic [3:0] q_b;
    logic [7:0] q_c;
    logic [3:0] q_d;
    logic       q_e;
    logic [NDUT-1:0] tc, wr, dn;
    logic [15:0] obs_q [NDUT];

    assign obs_q[0] = {13'b0, q_a};
    assign obs_q[1] = {12'b0, q_b};
    assign obs_q[2] = {8'b0, q_c};
    assign obs_q[3] = {12'b0, q_d};
    assign obs_q[4] = {15'b0, q_e};

    always #5 clk = ~clk;

    counter_mod #(.BW(3), .MODULO(8), .MODE(MODE_WRAP), .RST_VAL(0)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .up_i(up), .clr_i(clr), .load_i(load),
        .load_val_i(lv[2:0]), .counter_val_o(q_a), .tc_o(tc[0]), .wrap_o(wr[0]), .done_o(dn[0]));
    counter_mod #(.BW(4), .MODULO(10), .MODE(MODE_WRAP), .RST_VAL(3)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .up_i(up), .clr_i(clr), .load_i(load),
        .load_val_i(lv[3:0]), .counter_val_o(q_b), .tc_o(tc[1]), .wrap_o(wr[1]), .done_o(dn[1]));
    counter_mod #(.BW(8), .MODULO(256), .MODE(MODE_SAT), .RST_VAL(0)) u_c (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .up_i(up), .clr_i(clr), .load_i(load),
        .load_val_i(lv[7:0]), .counter_val_o(q_c), .tc_o(tc[2]), .wrap_o(wr[2]), .done_o(dn[2]));
    counter_mod #(.BW(4), .MODULO(16), .MODE(MODE_ONESHOT), .RST_VAL(0)) u_d (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .up_i(up), .clr_i(clr), .load_i(load),
        .load_val_i(lv[3:0]), .counter_val_o(q_d), .tc_o(tc[3]), .wrap_o(wr[3]), .done_o(dn[3]));
    counter_mod #(.BW(1), .MODULO(2), .MODE(MODE_WRAP), .RST_VAL(0)) u_e (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .up_i(up), .clr_i(clr), .load_i(load),
        .load_val_i(lv[0:0]), .counter_val_o(q_e), .tc_o(tc[4]), .wrap_o(wr[4]), .done_o(dn[4]));

    int unsigned m_cnt  [NDUT];
    bit          m_done [NDUT];
    bit          m_wrap [NDUT];
    int unsigned m_pre;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NDUT; i++) begin
            m_cnt[i]  = cfg_rst[i];
            m_done[i] = 1'b0;
            m_wrap[i] = 1'b0;
        end
        m_pre = 0;
    endtask

    function automatic int unsigned terminal(input int i, input bit dir_up);
        return dir_up ? cfg_mod[i] - 1 : 0;
    endfunction

    task automatic check_regs();
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("q[%0d]", i), obs_q[i], m_cnt[i]);
            check($sformatf("wrap[%0d]", i), wr[i], m_wrap[i]);
            check($sformatf("done[%0d]", i), dn[i], m_done[i]);
        end
    endtask

    // One clock: check tc with current inputs, clock, advance model, check registers.
    task automatic cycle();
        bit strobe;
        int unsigned lval;
        strobe = en && (m_pre == PRE_DIV - 1);
        #1;
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("tc[%0d]", i), tc[i],
                  strobe && !m_done[i] && (m_cnt[i] == terminal(i, up)));
        end
        @(posedge clk);
        for (int i = 0; i < NDUT; i++) begin
            m_wrap[i] = 1'b0;
            if (clr) begin
                m_cnt[i]  = cfg_rst[i];
                m_done[i] = 1'b0;
            end else if (load) begin
                lval      = lv % (1 << cfg_bw[i]);
                m_cnt[i]  = (lval >= cfg_mod[i]) ? cfg_mod[i] - 1 : lval;
                m_done[i] = 1'b0;
            end else if (strobe && !m_done[i]) begin
                if (m_cnt[i] != terminal(i, up))
                    m_cnt[i] = up ? m_cnt[i] + 1 : m_cnt[i] - 1;
                else if (cfg_mode[i] == 0) begin
                    m_cnt[i]  = up ? 0 : cfg_mod[i] - 1;
                    m_wrap[i] = 1'b1;
                end else if (cfg_mode[i] == 2)
                    m_done[i] = 1'b1;
            end
        end
        if (clr || load) m_pre = 0;
        else if (en) m_pre = strobe ? 0 : m_pre + 1;
        @(negedge clk);
        check_regs();
        $display("cyc %0d en=%0b up=%0b clr=%0b ld=%0b lv=%0d q=%0d/%0d/%0d/%0d/%0d wrap=%b done=%b",
                 cyc, en, up, clr, load, lv, q_a, q_b, q_c, q_d, q_e, wr, dn);
        cyc++;
    endtask

    task automatic drive(input bit e, input bit u, input bit c, input bit l, input logic [15:0] v);
        en = e; up = u; clr = c; load = l; lv = v;
        cycle();
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0; lv = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_regs();
        rst_n = 1'b1;

        // wrap run, then modulo-10 down count from 2
        for (int k = 0; k < 10; k++) drive(1, 1, 0, 0, 0);
        drive(0, 0, 0, 1, 16'd2);
        for (int k = 0; k < 6; k++) drive(1, 0, 0, 0, 0);
        // saturate from 250
        drive(0, 1, 0, 1, 16'd250);
        for (int k = 0; k < 12; k++) drive(1, 1, 0, 0, 0);
        // one-shot from 13, then rearm by load 3
        drive(0, 1, 0, 1, 16'd13);
        for (int k = 0; k < 6; k++) drive(1, 1, 0, 0, 0);
        drive(0, 1, 0, 1, 16'd3);
        for (int k = 0; k < 3; k++) drive(1, 1, 0, 0, 0);

        // clear beats load and enable; load 12 clamps to 9 on modulo 10
        drive(1, 1, 1, 1, 16'd12);
        check("prio_q_b", q_b, 3);
        drive(0, 1, 0, 1, 16'd12);
        check("clamp_q_b", q_b, 9);
        for (int k = 0; k < 3; k++) drive(1, 1, 0, 0, 0);

        // asynchronous reset mid-count
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_q_a", q_a, 0);
        check_regs();
        @(posedge clk);
        @(negedge clk);
        check_regs();
        rst_n = 1'b1;

        for (int k = 0; k < 300; k++) begin
            drive($urandom_range(0, 3) != 0,
                  ($urandom_range(0, 7) == 0) ? ~up : up,
                  $urandom_range(0, 15) == 0,
                  $urandom_range(0, 9) == 0,
                  16'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
